// File: rtl/pwm_duty_arbiter.sv
// Round-robin arbiter sharing the PWM duty register between the CPU (port 0)
// and the tone generator (port 1), with 4-phase req/ack and sample pacing.
module pwm_duty_arbiter #(
  parameter int unsigned DUTY_WIDTH    = 12,
  parameter int unsigned SAMPLE_PERIOD = 2500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [DUTY_WIDTH-1:0] duty0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic [DUTY_WIDTH-1:0] duty1,
  output logic                  ack1,
  output logic [DUTY_WIDTH-1:0] duty_out,
  output logic                  duty_update,
  output logic                  last_grant,
  output logic                  busy
);

  localparam int unsigned PW = $clog2(SAMPLE_PERIOD) + 1;
  localparam logic [PW-1:0] PACE_LOAD = PW'(SAMPLE_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACK0,
    ACK1
  } state_t;

  state_t                  state, state_n;
  logic [PW-1:0]           pace_cnt, pace_n;
  logic                    ack0_n, ack1_n, upd_n, lg_n;
  logic [DUTY_WIDTH-1:0]   duty_n;
  logic                    grant1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pace_cnt    <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      duty_out    <= '0;
      duty_update <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      state       <= state_n;
      pace_cnt    <= pace_n;
      ack0        <= ack0_n;
      ack1        <= ack1_n;
      duty_out    <= duty_n;
      duty_update <= upd_n;
      last_grant  <= lg_n;
    end
  end

  always_comb begin
    state_n = state;
    ack0_n  = ack0;
    ack1_n  = ack1;
    duty_n  = duty_out;
    upd_n   = 1'b0;
    lg_n    = last_grant;
    pace_n  = (pace_cnt != '0) ? pace_cnt - 1'b1 : '0;
    // On a tie the port that did not win last time goes next.
    grant1  = req1 & (~req0 | ~last_grant);
    case (state)
      IDLE: begin
        if (pace_cnt == '0 && (req0 | req1)) begin
          upd_n  = 1'b1;
          pace_n = PACE_LOAD;
          if (grant1) begin
            duty_n  = duty1;
            ack1_n  = 1'b1;
            lg_n    = 1'b1;
            state_n = ACK1;
          end else begin
            duty_n  = duty0;
            ack0_n  = 1'b1;
            lg_n    = 1'b0;
            state_n = ACK0;
          end
        end
      end
      ACK0: begin
        if (!req0) begin
          ack0_n  = 1'b0;
          state_n = IDLE;
        end
      end
      ACK1: begin
        if (!req1) begin
          ack1_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pwm_duty_arbiter.sv
// Directed bench for pwm_duty_arbiter with SAMPLE_PERIOD = 8.
module tb_pwm_duty_arbiter;

  localparam int unsigned DW = 12;
  localparam int unsigned SP = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [DW-1:0] duty0, duty1;
  logic          ack0, ack1;
  logic [DW-1:0] duty_out;
  logic          duty_update;
  logic          last_grant;
  logic          busy;

  int total = 0;
  int bad   = 0;

  pwm_duty_arbiter #(
    .DUTY_WIDTH   (DW),
    .SAMPLE_PERIOD(SP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .duty0      (duty0),
    .ack0       (ack0),
    .req1       (req1),
    .duty1      (duty1),
    .ack1       (ack1),
    .duty_out   (duty_out),
    .duty_update(duty_update),
    .last_grant (last_grant),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until duty_update is seen; n = edges taken, or -1 on timeout.
  task automatic wait_update(input int bound, output int n, output logic overlap);
    n = -1;
    overlap = 1'b0;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (ack0 && ack1) overlap = 1'b1;
      if (duty_update) begin
        n = i;
        break;
      end
    end
  endtask

  int   n;
  int   cnt;
  logic ov;
  logic seen;
  logic exp_port;

  initial begin
    reset = 1'b1;
    req0  = 1'b1;
    req1  = 1'b0;
    duty0 = 12'h3A5;
    duty1 = '0;

    // Reset held with req0 pending
    repeat (5) step();
    chk("rst_ack0", ack0, 0);
    chk("rst_duty", duty_out, 0);
    chk("rst_lg", last_grant, 1);
    chk("rst_busy", busy, 0);
    chk("rst_upd", duty_update, 0);
    reset = 1'b0;
    step();
    chk("first_ack0", ack0, 1);
    chk("first_duty", duty_out, 12'h3A5);
    chk("first_upd", duty_update, 1);
    chk("first_lg", last_grant, 0);
    chk("first_busy", busy, 1);
    step();
    chk("first_upd_1cyc", duty_update, 0);
    chk("first_ack_hold", ack0, 1);
    req0 = 1'b0;
    step();
    chk("release_ack0", ack0, 0);
    chk("release_busy", busy, 0);
    repeat (10) step();

    // Single requester pacing
    req0 = 1'b1;
    duty0 = 12'h100;
    step();
    chk("sp_ack0", ack0, 1);
    chk("sp_duty", duty_out, 12'h100);
    chk("sp_upd", duty_update, 1);
    req0 = 1'b0;
    step();
    chk("sp_rel", ack0, 0);
    req0 = 1'b1;
    duty0 = 12'h200;
    wait_update(20, n, ov);
    chk("sp_interval", n + 1, SP);
    chk("sp_duty2", duty_out, 12'h200);
    chk("sp_ack2", ack0, 1);
    req0 = 1'b0;
    step();

    // Tie round-robin from reset state: expect 0,1,0,1
    reset = 1'b1;
    step();
    reset = 1'b0;
    duty0 = 12'h111;
    duty1 = 12'h222;
    req0 = 1'b1;
    req1 = 1'b1;
    exp_port = 1'b0;
    for (int g = 0; g < 4; g++) begin
      wait_update(20, n, ov);
      chk("rr_timeout", (n > 0), 1);
      chk("rr_overlap", ov, 0);
      chk("rr_ack0", ack0, !exp_port);
      chk("rr_ack1", ack1, exp_port);
      chk("rr_duty", duty_out, exp_port ? 12'h222 : 12'h111);
      chk("rr_lg", last_grant, exp_port);
      if (exp_port) req1 = 1'b0; else req0 = 1'b0;
      step();
      if (exp_port) req1 = 1'b1; else req0 = 1'b1;
      exp_port = !exp_port;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (12) step();

    // Pending blocked requester
    duty0 = 12'h0AA;
    duty1 = 12'h0BB;
    req0 = 1'b1;
    step();
    chk("blk_ack0", ack0, 1);
    req1 = 1'b1;
    cnt = 0;
    repeat (3) begin
      step();
      cnt++;
    end
    chk("blk_ack1_low", ack1, 0);
    chk("blk_ack0_hold", ack0, 1);
    req0 = 1'b0;
    wait_update(20, n, ov);
    chk("blk_interval", cnt + n, SP);
    chk("blk_ack1", ack1, 1);
    chk("blk_ack0_off", ack0, 0);
    chk("blk_duty", duty_out, 12'h0BB);
    chk("blk_overlap", ov, 0);

    // Withdrawn request while pacing
    req1 = 1'b0;
    step();
    chk("wd_rel", ack1, 0);
    duty1 = 12'hCCC;
    req1 = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      step();
      if (ack1 || duty_update) seen = 1'b1;
    end
    req1 = 1'b0;
    repeat (10) begin
      step();
      if (ack1 || duty_update) seen = 1'b1;
    end
    chk("wd_no_grant", seen, 0);
    chk("wd_duty", duty_out, 12'h0BB);

    // Reset in the middle of a handshake
    duty1 = 12'h321;
    req1 = 1'b1;
    wait_update(20, n, ov);
    chk("mid_ack1", ack1, 1);
    chk("mid_duty", duty_out, 12'h321);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ack1", ack1, 0);
    chk("mid_rst_duty", duty_out, 0);
    chk("mid_rst_lg", last_grant, 1);
    chk("mid_rst_busy", busy, 0);
    step();
    reset = 1'b0;
    step();
    chk("mid_regrant_ack1", ack1, 1);
    chk("mid_regrant_duty", duty_out, 12'h321);
    chk("mid_regrant_upd", duty_update, 1);
    chk("mid_regrant_lg", last_grant, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
